tag_ctrl: RTL and testbench

TAG_CTRL -- requirements
Module: tag_ctrl

---
 rtl/tag_ctrl_pkg.sv | 20 ++
 rtl/tag_ctrl.sv | 153 +++++++++++++++
 tb/tb_tag_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_ctrl_pkg.sv
// Shared cache definitions for the tag controller: tag width, set geometry
// and FSM state encodings.
package tag_ctrl_pkg;

    // Tag width for a 32-bit address with 16-byte lines and 64 sets.
    localparam int TAG_W   = 22;
    localparam int SET_NUM = 64;
    localparam int IDX_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_CMP    = 3'd2,
        S_REFILL = 3'd3,
        S_WRITE  = 3'd4,
        S_RESP   = 3'd5,
        S_FLUSH  = 3'd6
    } state_e;

endpackage

// File: rtl/tag_ctrl.sv
// Direct-mapped tag lookup/refill controller driving an external tag RAM.
// Define YSYX22040228_TAG_FLUSH_EN to build the invalidate-all sweep.
module tag_ctrl
    import tag_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              resp_valid_o,
    output logic              resp_hit_o,
    output logic              refill_req_o,
    output logic [ADDR_W-1:0] refill_addr_o,
    input  logic              refill_ack_i,
    output logic [IDX_W-1:0]  teg_addr_o,
    output logic [TAG_W-1:0]  teg_o,
    output logic              teg_valid_o,
    output logic              teg_ena_o,
    input  logic [TAG_W-1:0]  teg_data_i,
    input  logic              teg_data_valid_i,
    input  logic              flush_i,
    output logic              flush_busy_o
);

    localparam int LINE_W = ADDR_W - OFF_W;

    state_e             state_q, state_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               hit_q, hit_d;
    logic               flush_go;
    logic [IDX_W-1:0]   line_idx;
    logic [TAG_W-1:0]   line_tag;

    // Byte offset never matters: lookups and refills are whole-line.
    logic unused_off;
    assign unused_off = ^req_addr_i[OFF_W-1:0];

    assign line_idx = line_q[IDX_W-1:0];
    assign line_tag = line_q[IDX_W +: TAG_W];

`ifdef YSYX22040228_TAG_FLUSH_EN
    logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
    assign flush_go = flush_i;
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush_go     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            hit_q   <= hit_d;
        end
    end

`ifdef YSYX22040228_TAG_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        hit_d         = hit_q;
`ifdef YSYX22040228_TAG_FLUSH_EN
        flush_cnt_d   = flush_cnt_q;
`endif
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        resp_hit_o    = 1'b0;
        refill_req_o  = 1'b0;
        refill_addr_o = '0;
        teg_addr_o    = line_idx;
        teg_o         = '0;
        teg_valid_o   = 1'b0;
        teg_ena_o     = 1'b0;
        flush_busy_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                // A pending flush wins over a simultaneous lookup.
                if (flush_go) begin
                    state_d = S_FLUSH;
`ifdef YSYX22040228_TAG_FLUSH_EN
                    flush_cnt_d = '0;
`endif
                end else if (req_valid_i) begin
                    state_d = S_READ;
                    line_d  = req_addr_i[ADDR_W-1:OFF_W];
                end
            end
            S_READ: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                hit_d   = teg_data_valid_i && (teg_data_i == line_tag);
                state_d = (teg_data_valid_i && (teg_data_i == line_tag)) ? S_RESP : S_REFILL;
            end
            S_REFILL: begin
                refill_req_o  = 1'b1;
                refill_addr_o = {line_q, {OFF_W{1'b0}}};
                if (refill_ack_i) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                teg_ena_o   = 1'b1;
                teg_valid_o = 1'b1;
                teg_o       = line_tag;
                hit_d       = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_hit_o   = hit_q;
                state_d      = S_IDLE;
            end
`ifdef YSYX22040228_TAG_FLUSH_EN
            S_FLUSH: begin
                teg_addr_o   = flush_cnt_q;
                teg_ena_o    = 1'b1;
                flush_busy_o = 1'b1;
                // Counter parks at the last set rather than wrapping.
                if (flush_cnt_q == IDX_W'(SET_NUM - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tag_ctrl.sv
// Scoreboard bench for tag_ctrl: random and directed lookups against a
// behavioural direct-mapped cache model, with a registered tag RAM model.
module tb_tag_ctrl;
    import tag_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [31:0]       req_addr_i;
    logic              resp_valid_o;
    logic              resp_hit_o;
    logic              refill_req_o;
    logic [31:0]       refill_addr_o;
    logic              refill_ack_i;
    logic [5:0]        teg_addr_o;
    logic [TAG_W-1:0]  teg_o;
    logic              teg_valid_o;
    logic              teg_ena_o;
    logic [TAG_W-1:0]  teg_data_i;
    logic              teg_data_valid_i;
    logic              flush_i;
    logic              flush_busy_o;

    tag_ctrl #(.ADDR_W(32), .OFF_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .resp_valid_o     (resp_valid_o),
        .resp_hit_o       (resp_hit_o),
        .refill_req_o     (refill_req_o),
        .refill_addr_o    (refill_addr_o),
        .refill_ack_i     (refill_ack_i),
        .teg_addr_o       (teg_addr_o),
        .teg_o            (teg_o),
        .teg_valid_o      (teg_valid_o),
        .teg_ena_o        (teg_ena_o),
        .teg_data_i       (teg_data_i),
        .teg_data_valid_i (teg_data_valid_i),
        .flush_i          (flush_i),
        .flush_busy_o     (flush_busy_o)
    );

    always #5 clk = ~clk;

    // Tag RAM with registered read port, as the parent would provide.
    logic [TAG_W-1:0] ram_tag [64];
    logic             ram_v   [64];
    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_tag[i] = '0;
            ram_v[i]   = 1'b0;
        end
        teg_data_i       = '0;
        teg_data_valid_i = 1'b0;
    end
    always @(posedge clk) begin
        if (teg_ena_o) begin
            ram_tag[teg_addr_o] <= teg_o;
            ram_v[teg_addr_o]   <= teg_valid_o;
        end else begin
            teg_data_i       <= ram_tag[teg_addr_o];
            teg_data_valid_i <= ram_v[teg_addr_o];
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference cache: which tag each set holds, if any.
    bit          ref_v   [64];
    int unsigned ref_tag [64];

    bit          exp_hit_q [$];
    int unsigned exp_wr_idx [$];
    int unsigned exp_wr_tag [$];
    logic [31:0] exp_refill_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: responses, tag writes and refill address, sampled on negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid_o) begin
                if (exp_hit_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    bit e;
                    e = exp_hit_q.pop_front();
                    chk("resp_hit", resp_hit_o, e);
                    $display("resp hit=%0d expected=%0d", resp_hit_o, e);
                end
            end
            if (teg_ena_o && teg_valid_o) begin
                if (exp_wr_idx.size() == 0) begin
                    chk("write_unexpected", 1, 0);
                end else begin
                    int unsigned wi, wt;
                    wi = exp_wr_idx.pop_front();
                    wt = exp_wr_tag.pop_front();
                    chk("write_index", teg_addr_o, wi);
                    chk("write_tag", teg_o, wt);
                end
            end
            if (refill_req_o) begin
                chk("refill_addr", refill_addr_o, exp_refill_addr);
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input int delay);
        int unsigned idx, tag;
        bit hit, saw_refill, got;
        int k;
        idx = (addr >> 4) & 63;
        tag = addr >> 10;
        hit = ref_v[idx] && (ref_tag[idx] == tag);
        @(negedge clk);
        for (k = 0; k < 100 && !req_ready_o; k++) @(negedge clk);
        if (!req_ready_o) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        exp_hit_q.push_back(hit);
        if (!hit) begin
            exp_wr_idx.push_back(idx);
            exp_wr_tag.push_back(tag);
            ref_v[idx]   = 1'b1;
            ref_tag[idx] = tag;
        end
        exp_refill_addr = addr & 32'hFFFF_FFF0;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        $display("req addr=0x%08h idx=%0d tag=0x%0h expect_hit=%0d delay=%0d", addr, idx, tag, hit, delay);
        if (hit) begin
            saw_refill = 1'b0;
            got = 1'b0;
            for (k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (refill_req_o) saw_refill = 1'b1;
                if (resp_valid_o) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("hit_resp_seen", got, 1);
            chk("hit_latency", k, 3);
            chk("hit_no_refill", saw_refill, 0);
        end else begin
            got = 1'b0;
            for (k = 0; k < 10; k++) begin
                @(negedge clk);
                if (refill_req_o) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("refill_seen", got, 1);
            if (!got) return;
            for (int i = 0; i < delay; i++) begin
                chk("refill_hold", refill_req_o, 1);
                @(negedge clk);
            end
            chk("refill_hold", refill_req_o, 1);
            refill_ack_i = 1'b1;
            @(negedge clk);
            refill_ack_i = 1'b0;
            got = 1'b0;
            for (k = 0; k < 10; k++) begin
                @(negedge clk);
                if (resp_valid_o) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("miss_resp_seen", got, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        for (int i = 0; i < 64; i++) begin
            ref_v[i]   = 1'b0;
            ref_tag[i] = 0;
        end
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        refill_ack_i = 1'b0;
        flush_i      = 1'b0;
        exp_refill_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_refill_req", refill_req_o, 0);
        chk("rst_refill_addr", refill_addr_o, 0);
        chk("rst_teg_ena", teg_ena_o, 0);
        chk("rst_teg_addr", teg_addr_o, 0);
        chk("rst_flush_busy", flush_busy_o, 0);
        rst = 1'b0;

        // Cold miss, hit, conflict eviction and slow refill.
        do_req(32'h0000_1230, 0);
        do_req(32'h0000_1230, 0);
        do_req(32'h0000_1630, 0);
        do_req(32'h0000_1230, 0);
        do_req(32'h0000_1630, 10);
        do_req(32'h0000_1630, 0);

        // Reset during refill: abandoned, no response, model untouched.
        @(negedge clk);
        for (int k = 0; k < 100 && !req_ready_o; k++) @(negedge clk);
        exp_refill_addr = 32'h0000_2F40;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_2F40;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (refill_req_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_mid_refill_seen", got, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_refill_req", refill_req_o, 0);
        chk("rst_mid_ready", req_ready_o, 1);
        chk("rst_mid_teg_ena", teg_ena_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_no_resp", resp_valid_o, 0);
        end
        $display("reset mid-refill done");

`ifdef YSYX22040228_TAG_FLUSH_EN
        @(negedge clk);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_1230;
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("flush_ena", teg_ena_o, 1);
            chk("flush_valid", teg_valid_o, 0);
            chk("flush_index", teg_addr_o, i);
            chk("flush_busy", flush_busy_o, 1);
        end
        @(negedge clk);
        chk("flush_done_busy", flush_busy_o, 0);
        chk("flush_done_ready", req_ready_o, 1);
        for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
        $display("flush sweep done");
        do_req(32'h0000_1230, 0);
`else
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("noflush_busy", flush_busy_o, 0);
        chk("noflush_teg_ena", teg_ena_o, 0);
        chk("noflush_ready", req_ready_o, 1);
        $display("flush ignored in default build");
        do_req(32'h0000_1630, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int unsigned t;
            t = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) t = t | 32'h003F_0000;
            a = (t << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            do_req(a, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        chk("resp_queue_empty", exp_hit_q.size(), 0);
        chk("write_queue_empty", exp_wr_idx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
